// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: opcodes, FSM states, ALU codes, PC/RegDst selects.
package mc_ctrl_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned ST_W    = 3;
   localparam int unsigned ALUOP_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IF     = 3'b000,
      ST_ID     = 3'b001,
      ST_EXE_LS = 3'b010,
      ST_MEM    = 3'b011,
      ST_WB_LD  = 3'b100,
      ST_EXE_BR = 3'b101,
      ST_EXE_AL = 3'b110,
      ST_WB_AL  = 3'b111
   } state_t;

   localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
   localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
   localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
   localparam logic [OP_W-1:0] OP_XORI  = 6'b010011;
   localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b011100;
   localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
   localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
   localparam logic [OP_W-1:0] OP_J     = 6'b111000;
   localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
   localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

   localparam logic [ALUOP_W-1:0] ALU_ADD  = 3'b000;
   localparam logic [ALUOP_W-1:0] ALU_SUB  = 3'b001;
   localparam logic [ALUOP_W-1:0] ALU_SLL  = 3'b010;
   localparam logic [ALUOP_W-1:0] ALU_OR   = 3'b011;
   localparam logic [ALUOP_W-1:0] ALU_AND  = 3'b100;
   localparam logic [ALUOP_W-1:0] ALU_SLTU = 3'b101;
   localparam logic [ALUOP_W-1:0] ALU_SLT  = 3'b110;
   localparam logic [ALUOP_W-1:0] ALU_XOR  = 3'b111;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_RS  = 2'b10;
   localparam logic [1:0] PCSRC_JMP = 2'b11;

   localparam logic [1:0] RD_RA = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RD = 2'b10;

   function automatic logic is_jump(input logic [OP_W-1:0] op);
      return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
   endfunction

   function automatic logic is_branch(input logic [OP_W-1:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
   endfunction

   function automatic logic is_mem(input logic [OP_W-1:0] op);
      return (op == OP_SW) || (op == OP_LW);
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: ALU operation, operand selects, immediate extension, R-type and legality.
module alu_op_decode
   import mc_ctrl_pkg::*;
(
   input  logic [OP_W-1:0]    op,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               ext_sel,
   output logic               alu_src_a,
   output logic               alu_src_b,
   output logic               r_type,
   output logic               legal
);

   always_comb begin
      alu_op    = ALU_ADD;
      ext_sel   = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      r_type    = 1'b0;
      legal     = 1'b1;
      case (op)
         OP_ADD:   r_type = 1'b1;
         OP_SUB: begin
            alu_op = ALU_SUB;
            r_type = 1'b1;
         end
         OP_ADDIU: begin
            ext_sel   = 1'b1;
            alu_src_b = 1'b1;
         end
         OP_AND: begin
            alu_op = ALU_AND;
            r_type = 1'b1;
         end
         OP_ANDI: begin
            alu_op    = ALU_AND;
            alu_src_b = 1'b1;
         end
         OP_ORI: begin
            alu_op    = ALU_OR;
            alu_src_b = 1'b1;
         end
         OP_XORI: begin
            alu_op    = ALU_XOR;
            alu_src_b = 1'b1;
         end
         OP_SLL: begin
            alu_op    = ALU_SLL;
            alu_src_a = 1'b1;
            r_type    = 1'b1;
         end
         OP_SLTI: begin
            alu_op    = ALU_SLT;
            ext_sel   = 1'b1;
            alu_src_b = 1'b1;
         end
         OP_SW, OP_LW: begin
            ext_sel   = 1'b1;
            alu_src_b = 1'b1;
         end
         // branches compare rs-rt; the offset is sign-extended for the target adder
         OP_BEQ, OP_BNE, OP_BLTZ: begin
            alu_op  = ALU_SUB;
            ext_sel = 1'b1;
         end
         OP_J, OP_JR, OP_JAL, OP_HALT: ;
         default:  legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: sequences IF/ID/EXE/MEM/WB and decodes datapath controls from state and op.
// Build option MC_CTRL_ILLEGAL_TRAP_EN: unknown opcodes halt and raise a sticky 'illegal' output.
module multi_cycle_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic               CLK,
   input  logic               RST_n,
   input  logic [OP_W-1:0]    op,
   input  logic               zero,
   input  logic               sign,
   output logic               PCWre,
   output logic               IRWre,
   output logic               InsMemRW,
   output logic               ALUSrcA,
   output logic               ALUSrcB,
   output logic               ExtSel,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               mRD,
   output logic               mWR,
   output logic               DBDataSrc,
   output logic               RegWre,
   output logic               WrRegDSrc,
   output logic [1:0]         RegDst,
   output logic [1:0]         PCSrc,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   output logic               illegal,
`endif
   output logic [ST_W-1:0]    state
);

   state_t               cur;
   logic                 halted;
   logic [ALUOP_W-1:0]   dec_alu_op;
   logic                 dec_ext_sel;
   logic                 dec_src_a;
   logic                 dec_src_b;
   logic                 dec_r_type;
   logic                 dec_legal;
   logic                 br_taken;

   alu_op_decode u_dec (
      .op        (op),
      .alu_op    (dec_alu_op),
      .ext_sel   (dec_ext_sel),
      .alu_src_a (dec_src_a),
      .alu_src_b (dec_src_b),
      .r_type    (dec_r_type),
      .legal     (dec_legal)
   );

   // HALT reuses the ID encoding; the sticky halted bit freezes the FSM until reset
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         cur    <= ST_IF;
         halted <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         illegal <= 1'b0;
`endif
      end else if (!halted) begin
         case (cur)
            ST_IF: cur <= ST_ID;
            ST_ID: begin
               if (is_jump(op))        cur <= ST_IF;
               else if (op == OP_HALT) halted <= 1'b1;
               else if (is_branch(op)) cur <= ST_EXE_BR;
               else if (is_mem(op))    cur <= ST_EXE_LS;
               else if (!dec_legal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                  halted  <= 1'b1;
                  illegal <= 1'b1;
`else
                  cur <= ST_IF;
`endif
               end else begin
                  cur <= ST_EXE_AL;
               end
            end
            ST_EXE_AL: cur <= ST_WB_AL;
            ST_EXE_BR: cur <= ST_IF;
            ST_EXE_LS: cur <= ST_MEM;
            ST_MEM:    cur <= (op == OP_SW) ? ST_IF : ST_WB_LD;
            ST_WB_AL:  cur <= ST_IF;
            ST_WB_LD:  cur <= ST_IF;
            default:   cur <= ST_IF;
         endcase
      end
   end

   assign state = cur;

   always_comb begin
      case (op)
         OP_BEQ:  br_taken = zero;
         OP_BNE:  br_taken = !zero;
         OP_BLTZ: br_taken = sign;
         default: br_taken = 1'b0;
      endcase
   end

   // Moore decode; ALU controls are held across EXE, MEM and WB so ALU outputs stay stable
   always_comb begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      ALUOp     = ALU_ADD;
      mRD       = 1'b0;
      mWR       = 1'b0;
      DBDataSrc = 1'b0;
      RegWre    = 1'b0;
      WrRegDSrc = 1'b0;
      RegDst    = RD_RA;
      PCSrc     = PCSRC_SEQ;
      if (!halted) begin
         if (cur != ST_IF && cur != ST_ID) begin
            ALUOp   = dec_alu_op;
            ALUSrcA = dec_src_a;
            ALUSrcB = dec_src_b;
            ExtSel  = dec_ext_sel;
         end
         case (cur)
            ST_IF: begin
               IRWre    = 1'b1;
               InsMemRW = 1'b1;
            end
            ST_ID: begin
               if (is_jump(op)) begin
                  PCWre = 1'b1;
                  PCSrc = (op == OP_JR) ? PCSRC_RS : PCSRC_JMP;
                  if (op == OP_JAL) begin
                     RegWre    = 1'b1;
                     RegDst    = RD_RA;
                     WrRegDSrc = 1'b0;
                  end
               end
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
               else if (!dec_legal) begin
                  PCWre = 1'b1;
               end
`endif
            end
            ST_EXE_BR: begin
               PCWre = 1'b1;
               PCSrc = br_taken ? PCSRC_BR : PCSRC_SEQ;
            end
            ST_MEM: begin
               if (op == OP_SW) begin
                  mWR   = 1'b1;
                  PCWre = 1'b1;
               end else begin
                  mRD = 1'b1;
               end
            end
            ST_WB_AL: begin
               RegWre    = 1'b1;
               WrRegDSrc = 1'b1;
               RegDst    = dec_r_type ? RD_RD : RD_RT;
               PCWre     = 1'b1;
            end
            ST_WB_LD: begin
               RegWre    = 1'b1;
               WrRegDSrc = 1'b1;
               DBDataSrc = 1'b1;
               RegDst    = RD_RT;
               PCWre     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle control vectors for each instruction class.
module tb_multi_cycle_ctrl;

   logic       CLK = 1'b0;
   logic       RST_n = 1'b0;
   logic [5:0] op = 6'b000000;
   logic       zero = 1'b0;
   logic       sign = 1'b0;
   logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
   logic [2:0] ALUOp;
   logic       mRD, mWR, DBDataSrc, RegWre, WrRegDSrc;
   logic [1:0] RegDst, PCSrc;
   logic [2:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic       illegal;
`endif

   int passed = 0;
   int total  = 0;

   multi_cycle_ctrl dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .op        (op),
      .zero      (zero),
      .sign      (sign),
      .PCWre     (PCWre),
      .IRWre     (IRWre),
      .InsMemRW  (InsMemRW),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ExtSel    (ExtSel),
      .ALUOp     (ALUOp),
      .mRD       (mRD),
      .mWR       (mWR),
      .DBDataSrc (DBDataSrc),
      .RegWre    (RegWre),
      .WrRegDSrc (WrRegDSrc),
      .RegDst    (RegDst),
      .PCSrc     (PCSrc),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      .illegal   (illegal),
`endif
      .state     (state)
   );

   always #5 CLK = ~CLK;

   logic [20:0] obs;
   assign obs = {state, PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
                 mRD, mWR, DBDataSrc, RegWre, WrRegDSrc, RegDst, PCSrc};

   // Pack an expected control vector in the same field order as obs
   function automatic logic [20:0] pk(input logic [2:0] st, input logic pcw, input logic irw,
                                      input logic imr, input logic asa, input logic asb,
                                      input logic ext, input logic [2:0] aop, input logic mrd,
                                      input logic mwr, input logic dbs, input logic rw,
                                      input logic wrs, input logic [1:0] rd, input logic [1:0] pcs);
      return {st, pcw, irw, imr, asa, asb, ext, aop, mrd, mwr, dbs, rw, wrs, rd, pcs};
   endfunction

   function automatic logic [20:0] v_if();
      return pk(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
   endfunction

   function automatic logic [20:0] v_idle(input logic [2:0] st);
      return pk(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
   endfunction

   task automatic test_reset();
      logic [20:0] e;
      #12;
      e = v_if();
      total++;
      if (obs !== e) $display("FAIL reset_hold: got %h want %h", obs, e);
      else passed++;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      total++;
      if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal);
      else passed++;
`endif
      #4 RST_n = 1'b1;
      @(negedge CLK);
      total++;
      if (obs !== e) $display("FAIL reset_release: got %h want %h", obs, e);
      else passed++;
   endtask

   task automatic test_alu_ops();
      logic [5:0]  t_op  [9];
      logic [2:0]  t_aop [9];
      logic [2:0]  t_sel [9];
      logic [1:0]  t_rd  [9];
      logic [20:0] e [4];
      t_op  = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                6'b010010, 6'b010011, 6'b011000, 6'b011100};
      t_aop = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b100, 3'b011, 3'b111, 3'b010, 3'b110};
      // {ALUSrcA, ALUSrcB, ExtSel}
      t_sel = '{3'b000, 3'b000, 3'b011, 3'b000, 3'b010, 3'b010, 3'b010, 3'b100, 3'b011};
      t_rd  = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
      for (int k = 0; k < 9; k++) begin
         op   = t_op[k];
         e[0] = v_if();
         e[1] = v_idle(3'b001);
         e[2] = pk(3'b110, 1'b0, 1'b0, 1'b0, t_sel[k][2], t_sel[k][1], t_sel[k][0], t_aop[k],
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
         e[3] = pk(3'b111, 1'b1, 1'b0, 1'b0, t_sel[k][2], t_sel[k][1], t_sel[k][0], t_aop[k],
                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t_rd[k], 2'b00);
         for (int c = 0; c < 4; c++) begin
            total++;
            if (obs !== e[c]) $display("FAIL alu op=%b cyc%0d: got %h want %h", t_op[k], c, obs, e[c]);
            else passed++;
            @(negedge CLK);
         end
      end
   endtask

   task automatic test_lw();
      logic [20:0] e [5];
      op   = 6'b110001;
      e[0] = v_if();
      e[1] = v_idle(3'b001);
      e[2] = pk(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      e[3] = pk(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      e[4] = pk(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00);
      for (int c = 0; c < 5; c++) begin
         total++;
         if (obs !== e[c]) $display("FAIL lw cyc%0d: got %h want %h", c, obs, e[c]);
         else passed++;
         @(negedge CLK);
      end
   endtask

   task automatic test_branch();
      logic [5:0]  b_op [6];
      logic [1:0]  b_zs [6];
      logic [1:0]  b_pc [6];
      logic [20:0] e [3];
      b_op = '{6'b110100, 6'b110100, 6'b110101, 6'b110101, 6'b110110, 6'b110110};
      b_zs = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};   // {zero, sign}
      b_pc = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
      for (int k = 0; k < 6; k++) begin
         op   = b_op[k];
         zero = b_zs[k][1];
         sign = b_zs[k][0];
         e[0] = v_if();
         e[1] = v_idle(3'b001);
         e[2] = pk(3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, b_pc[k]);
         for (int c = 0; c < 3; c++) begin
            total++;
            if (obs !== e[c]) $display("FAIL branch op=%b zs=%b cyc%0d: got %h want %h", b_op[k], b_zs[k], c, obs, e[c]);
            else passed++;
            @(negedge CLK);
         end
      end
      zero = 1'b0;
      sign = 1'b0;
   endtask

   task automatic test_jumps();
      logic [5:0]  j_op [3];
      logic [20:0] e_id [3];
      logic [20:0] e;
      j_op    = '{6'b111000, 6'b111001, 6'b111010};
      e_id[0] = pk(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
      e_id[1] = pk(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
      e_id[2] = pk(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11);
      for (int k = 0; k < 3; k++) begin
         op = j_op[k];
         e  = v_if();
         total++;
         if (obs !== e) $display("FAIL jump op=%b IF: got %h want %h", j_op[k], obs, e);
         else passed++;
         @(negedge CLK);
         total++;
         if (obs !== e_id[k]) $display("FAIL jump op=%b ID: got %h want %h", j_op[k], obs, e_id[k]);
         else passed++;
         @(negedge CLK);
      end
   endtask

   task automatic test_sw_reset();
      logic [20:0] e [4];
      op   = 6'b110000;
      e[0] = v_if();
      e[1] = v_idle(3'b001);
      e[2] = pk(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      e[3] = pk(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      for (int c = 0; c < 3; c++) begin
         total++;
         if (obs !== e[c]) $display("FAIL sw_pre cyc%0d: got %h want %h", c, obs, e[c]);
         else passed++;
         if (c < 2) @(negedge CLK);
      end
      // abort in EXE_LS with a short asynchronous reset pulse
      #1 RST_n = 1'b0;
      #1;
      total++;
      if (obs !== e[0]) $display("FAIL sw_async_reset: got %h want %h", obs, e[0]);
      else passed++;
      #1 RST_n = 1'b1;
      @(negedge CLK);
      total++;
      if (obs !== e[1] || mWR !== 1'b0) $display("FAIL sw_after_reset: got %h want %h", obs, e[1]);
      else passed++;
      for (int c = 2; c < 4; c++) begin
         @(negedge CLK);
         total++;
         if (obs !== e[c]) $display("FAIL sw_rerun cyc%0d: got %h want %h", c, obs, e[c]);
         else passed++;
      end
      @(negedge CLK);
   endtask

   task automatic recover_reset();
      logic [20:0] e;
      e = v_if();
      #1 RST_n = 1'b0;
      #1;
      total++;
      if (obs !== e) $display("FAIL halt_async_reset: got %h want %h", obs, e);
      else passed++;
      #4 RST_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_halt();
      logic [20:0] e;
      int          bad;
      op = 6'b111111;
      e  = v_if();
      total++;
      if (obs !== e) $display("FAIL halt IF: got %h want %h", obs, e);
      else passed++;
      e   = v_idle(3'b001);
      bad = 0;
      for (int c = 0; c < 21; c++) begin
         @(negedge CLK);
         if (obs !== e && bad == 0) begin
            bad = 1;
            $display("FAIL halt_hold cyc%0d: got %h want %h", c, obs, e);
         end
      end
      total++;
      if (bad == 0) passed++;
      recover_reset();
   endtask

   task automatic test_unknown();
      logic [20:0] e;
      op = 6'b101010;
      e  = v_if();
      total++;
      if (obs !== e) $display("FAIL unknown IF: got %h want %h", obs, e);
      else passed++;
      @(negedge CLK);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      e = v_idle(3'b001);
      total++;
      if (obs !== e || illegal !== 1'b0) $display("FAIL unknown ID: got %h/%b want %h/0", obs, illegal, e);
      else passed++;
      @(negedge CLK);
      total++;
      if (obs !== e || illegal !== 1'b1) $display("FAIL unknown trap: got %h/%b want %h/1", obs, illegal, e);
      else passed++;
      recover_reset();
      total++;
      if (illegal !== 1'b0) $display("FAIL unknown illegal_clear: got %b want 0", illegal);
      else passed++;
`else
      e = pk(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      total++;
      if (obs !== e) $display("FAIL unknown ID nop: got %h want %h", obs, e);
      else passed++;
      @(negedge CLK);
      e = v_if();
      total++;
      if (obs !== e) $display("FAIL unknown next IF: got %h want %h", obs, e);
      else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_lw();
      test_branch();
      test_jumps();
      test_sw_reset();
      test_halt();
      test_unknown();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
